line_burst_adaptor: RTL and testbench
=====================================

Name: line_burst_adaptor

Overview:
- Memory-side responder for the 256-bit cacheline (pmem) interface; sits directly below the eviction write buffer.
- Accepts whole-line read/write requests and serves them as fixed-length bursts of 64-bit beats on the physical-memory burst port.
- Completes each line request with a single-cycle line_resp.

Parameters:
- BEATS, 4, beats per line.
- BEAT_WIDTH, 64, bits per beat.
- LINE_WIDTH, 256, bits per line; must equal BEATS*BEAT_WIDTH.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- line_address  input  32  byte address of line request.
- line_rdata  output  LINE_WIDTH  read line data, valid when line_resp=1 for a read.
- line_wdata  input  LINE_WIDTH  write line data.
- line_read  input  1  read request, held high until line_resp.
- line_write  input  1  write request, held high until line_resp.
- line_resp  output  1  one-cycle completion pulse.
- burst_address  output  32  line-aligned burst address.
- burst_rdata  input  BEAT_WIDTH  read beat data.
- burst_wdata  output  BEAT_WIDTH  write beat data.
- burst_read  output  1  burst read request.
- burst_write  output  1  burst write request.
- burst_resp  input  1  one beat accepted/returned this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; beat counter=0; line buffer=0; latched address=0.
  - All outputs 0.
  - An in-flight burst is abandoned; no line_resp is issued for it.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - On line_write: latch the address with low log2(LINE_WIDTH/8) bits forced to 0, latch line_wdata into the buffer, clear the counter, then go to WR_BURST.
  - Else on line_read: latch the aligned address, clear the counter, then go to RD_BURST.
  - If both are high, the write wins and the read is not serviced in that pass.
- RD_BURST:
  - burst_read=1; burst_address=latched address, constant for the whole burst.
  - On each burst_resp, store burst_rdata into buffer slice [cnt*BEAT_WIDTH +: BEAT_WIDTH] and increment cnt.
  - On burst_resp with cnt=BEATS-1, go to DONE.
- WR_BURST:
  - burst_write=1; burst_address=latched address; burst_wdata=buffer slice[cnt], combinational from cnt.
  - Advance on burst_resp exactly as in RD_BURST.
  - Beats go lowest slice first.
- DONE:
  - line_resp=1 for exactly one cycle, then IDLE.
  - line_rdata=buffer. The buffer holds its value until the next read beat or write latch.
- Outside DONE, line_resp=0.
- burst_read and burst_write are never high together and are 0 in IDLE and DONE.
- Handshake:
  - The requester deasserts its request in the cycle after line_resp.
  - Because DONE always returns to IDLE, a request that is still high in IDLE is treated as a new request.
- Latency:
  - Request seen in IDLE at cycle 0.
  - burst_read/burst_write high from cycle 1.
  - With burst_resp every cycle, beats land in cycles 1-4 and line_resp is high in cycle 5.
  - Each cycle of burst_resp=0 adds one cycle.
- Line-side inputs are ignored outside IDLE; address and data are latched only in IDLE.
- Counter width is clog2(BEATS). It wraps to 0 on entry to DONE.

Optional Feature:
- Macro: LINE_BURST_ADAPTOR_BYPASS_EN.
- With the macro defined:
  - Keep a valid bit plus the aligned address of the last written line. The buffer already holds that line's data.
  - The valid bit is set when a write completes, and cleared on reset and when a read burst starts.
  - A read in IDLE whose aligned address matches a valid entry goes straight to DONE with no burst, so line_resp is high in cycle 1.
  - line_rdata returns the buffered write data.
- Without the macro: every read performs a full burst; no valid bit or compare logic is present.

Test Plan:
- Read 0x0000_1234, zero-wait memory returning beats 64'h1111.., 64'h2222.., 64'h3333.., 64'h4444.. -> burst_address=0x0000_1220 for 4 cycles; line_resp in cycle 5; line_rdata={4444..,3333..,2222..,1111..}.
- Write 0x0000_2000 with line_wdata={D3,D2,D1,D0} -> burst_write for 4 beats; burst_wdata sequence D0,D1,D2,D3; line_resp one cycle after the 4th burst_resp; burst_read never high.
- Read with 3 idle cycles between each burst_resp -> burst_address and burst_read stable throughout; line_resp exactly once, in cycle 17.
- line_read=line_write=1 at 0x0000_3000 -> only a write burst occurs; one line_resp.
- rst=0 after the 2nd read beat -> all outputs 0 in the same cycle; after release, a new read to 0x40 completes normally with fresh data.
- Bypass: write line L to 0x100, then read 0x104.
  - With LINE_BURST_ADAPTOR_BYPASS_EN: line_resp in cycle 1, line_rdata=L, no burst_read.
  - Without the macro: full 4-beat read burst to 0x100.

Source files
------------

// File: rtl/line_burst_adaptor.sv
// Whole-line read/write responder that serves each line as a burst of BEATS beats.
// Optional write-hit read bypass: define LINE_BURST_ADAPTOR_BYPASS_EN.
module line_burst_adaptor #(
    parameter int BEATS      = 4,
    parameter int BEAT_WIDTH = 64,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           line_address,
    output logic [LINE_WIDTH-1:0] line_rdata,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    input  logic                  line_read,
    input  logic                  line_write,
    output logic                  line_resp,
    output logic [31:0]           burst_address,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    output logic                  burst_read,
    output logic                  burst_write,
    input  logic                  burst_resp
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt;
    logic [LINE_WIDTH-1:0]   line_buf;
    logic [31:0]             addr_q;
    logic [31:0]             aligned_addr;
    logic                    last_beat;
    logic                    byp_hit;

    assign aligned_addr = line_address & ~(32'(LINE_WIDTH / 8) - 32'd1);
    assign last_beat    = burst_resp && (cnt == CNT_W'(BEATS - 1));
    assign line_rdata   = line_buf;

`ifdef LINE_BURST_ADAPTOR_BYPASS_EN
    logic        byp_valid;
    logic [31:0] byp_addr;

    assign byp_hit = byp_valid && (byp_addr == aligned_addr);

    // line_buf still holds the last written line, so only its address is tracked
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp_valid <= 1'b0;
            byp_addr  <= '0;
        end else if (state == WR_BURST && last_beat) begin
            byp_valid <= 1'b1;
            byp_addr  <= addr_q;
        end else if (state == IDLE && !line_write && line_read && !byp_hit) begin
            byp_valid <= 1'b0;
        end
    end
`else
    assign byp_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next    = state;
        line_resp     = 1'b0;
        burst_read    = 1'b0;
        burst_write   = 1'b0;
        burst_address = '0;
        burst_wdata   = '0;
        case (state)
            IDLE: begin
                if (line_write)     state_next = WR_BURST;
                else if (line_read) state_next = byp_hit ? DONE : RD_BURST;
            end
            RD_BURST: begin
                burst_read    = 1'b1;
                burst_address = addr_q;
                if (last_beat) state_next = DONE;
            end
            WR_BURST: begin
                burst_write   = 1'b1;
                burst_address = addr_q;
                burst_wdata   = line_buf[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH];
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                line_resp  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            line_buf <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_write) begin
                        addr_q   <= aligned_addr;
                        line_buf <= line_wdata;
                        cnt      <= '0;
                    end else if (line_read) begin
                        addr_q <= aligned_addr;
                        cnt    <= '0;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        line_buf[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= burst_rdata;
                        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                    end
                end
                WR_BURST: begin
                    if (burst_resp) cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Randomized bench for line_burst_adaptor: acts as the burst memory and the line requester.
// Build with LINE_BURST_ADAPTOR_BYPASS_EN to exercise the read bypass expectations.
module tb_line_burst_adaptor;

    localparam int BEATS = 4;
    localparam int BW    = 64;
    localparam int LW    = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   line_address;
    logic [LW-1:0] line_rdata;
    logic [LW-1:0] line_wdata;
    logic          line_read;
    logic          line_write;
    logic          line_resp;
    logic [31:0]   burst_address;
    logic [BW-1:0] burst_rdata;
    logic [BW-1:0] burst_wdata;
    logic          burst_read;
    logic          burst_write;
    logic          burst_resp;

    line_burst_adaptor #(.BEATS(BEATS), .BEAT_WIDTH(BW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .line_address(line_address), .line_rdata(line_rdata), .line_wdata(line_wdata),
        .line_read(line_read), .line_write(line_write), .line_resp(line_resp),
        .burst_address(burst_address), .burst_rdata(burst_rdata), .burst_wdata(burst_wdata),
        .burst_read(burst_read), .burst_write(burst_write), .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Memory behind the burst port, one entry per aligned line
    logic [LW-1:0] mem [logic [31:0]];
    bit            byp_valid = 1'b0;
    logic [31:0]   byp_addr  = '0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int pick_wait(input int fixed_wait);
        return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_resp"},  line_resp,     '0);
        check({tag, "_brd"},   burst_read,    '0);
        check({tag, "_bwr"},   burst_write,   '0);
        check({tag, "_baddr"}, burst_address, '0);
        check({tag, "_bwd"},   burst_wdata,   '0);
        check({tag, "_rdata"}, line_rdata,    '0);
    endtask

    // One line request; abort_beats>0 pulls reset once that many beats have been accepted.
    task automatic do_line(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [LW-1:0] wdata, input int fixed_wait,
                           input int abort_beats,
                           output logic [LW-1:0] rdata_out, output int resp_cycle);
        logic [31:0]   a;
        logic [LW-1:0] exp_line;
        int            cyc, beats, waits, wleft;
        bit            hit, done;
        a          = addr & 32'hFFFF_FFE0;
        rdata_out  = '0;
        resp_cycle = -1;
        @(posedge clk); #1;
        check("idle_resp", line_resp, '0);
        check("idle_brd", burst_read, '0);
        check("idle_bwr", burst_write, '0);
        line_address = addr;
        line_wdata   = wdata;
        line_read    = rd;
        line_write   = wr;
        hit = 1'b0;
`ifdef LINE_BURST_ADAPTOR_BYPASS_EN
        hit = !wr && rd && byp_valid && (byp_addr == a);
`endif
        if (!wr && !hit) begin
            byp_valid = 1'b0;
            if (!mem.exists(a)) mem[a] = rnd_line();
        end
        exp_line = wr ? wdata : mem[a];
        wleft = pick_wait(fixed_wait);
        beats = 0; waits = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            burst_resp = 1'b0;
            if (abort_beats > 0 && beats == abort_beats) begin
                rst        = 1'b0;
                line_read  = 1'b0;
                line_write = 1'b0;
                #1;
                check_all_zero("abort");
                byp_valid = 1'b0;
                #2 rst = 1'b1;
                return;
            end
            if (line_resp) begin
                check("resp_cycle", cyc, hit ? 1 : 1 + BEATS + waits);
                check("beat_count", beats, hit ? 0 : BEATS);
                check("resp_brd", burst_read, '0);
                check("resp_bwr", burst_write, '0);
                if (!wr) check("line_rdata", line_rdata, exp_line);
                rdata_out  = line_rdata;
                resp_cycle = cyc;
                line_read  = 1'b0;
                line_write = 1'b0;
                done       = 1'b1;
                if (wr) begin
                    mem[a]    = wdata;
                    byp_valid = 1'b1;
                    byp_addr  = a;
                end
            end else if (beats >= BEATS) begin
                check("resp_missing", line_resp, '1);
                line_read  = 1'b0;
                line_write = 1'b0;
                done       = 1'b1;
            end else begin
                check("burst_read", burst_read, (!wr && !hit) ? 1 : 0);
                check("burst_write", burst_write, wr ? 1 : 0);
                check("burst_addr", burst_address, a);
                if (wr) check("burst_wdata", burst_wdata, wdata[beats*BW +: BW]);
                if (wleft > 0) begin
                    wleft--;
                    waits++;
                end else begin
                    burst_resp  = 1'b1;
                    burst_rdata = exp_line[beats*BW +: BW];
                    beats++;
                    wleft = pick_wait(fixed_wait);
                end
                // line-side inputs must be ignored while a burst is in flight
                line_address = $urandom;
                line_wdata   = rnd_line();
            end
        end
        if (!done) check("timeout", 0, 1);
    endtask

    logic [LW-1:0] r, exp_l, dl;
    int            c;

    initial begin
        rst = 1'b0;
        line_address = '0; line_wdata = '0; line_read = 1'b0; line_write = 1'b0;
        burst_rdata = '0; burst_resp = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        exp_l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        mem[32'h0000_1220] = exp_l;
        do_line(1'b1, 1'b0, 32'h0000_1234, '0, 0, 0, r, c);
        check("tp_read_data", r, exp_l);
        check("tp_read_lat", c, 5);

        dl = rnd_line();
        do_line(1'b0, 1'b1, 32'h0000_2000, dl, 0, 0, r, c);
        check("tp_write_lat", c, 5);

        do_line(1'b1, 1'b0, 32'h0000_5008, '0, 3, 0, r, c);
        check("tp_wait_lat", c, 17);

        dl = rnd_line();
        do_line(1'b1, 1'b1, 32'h0000_3000, dl, 0, 0, r, c);
        check("tp_both_lat", c, 5);

        do_line(1'b1, 1'b0, 32'h0000_0080, '0, 0, 2, r, c);
        mem[32'h0000_0040] = rnd_line();
        do_line(1'b1, 1'b0, 32'h0000_0040, '0, 0, 0, r, c);
        check("tp_post_reset_data", r, mem[32'h0000_0040]);

        exp_l = rnd_line();
        do_line(1'b0, 1'b1, 32'h0000_0100, exp_l, 0, 0, r, c);
        do_line(1'b1, 1'b0, 32'h0000_0104, '0, 0, 0, r, c);
        check("tp_bypass_data", r, exp_l);
`ifdef LINE_BURST_ADAPTOR_BYPASS_EN
        check("tp_bypass_lat", c, 1);
`else
        check("tp_bypass_lat", c, 5);
`endif

        for (int i = 0; i < 60; i++) begin
            int unsigned op;
            logic [31:0] ad;
            op = $urandom_range(0, 3);
            ad = {24'h0, 3'($urandom_range(0, 7)), 5'($urandom)};
            do_line(op != 2, op >= 2, ad, rnd_line(), -1, 0, r, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
